mem_responder: RTL and testbench

Memory responder on the CPU's shared instruction/data memory interface. It answers the single-strobe read and write requests issued by the multicycle controller/datapath pair: it captures the request, inserts a fixed number of wait states, and completes the transfer with a one-cycle `ready` pulse. It holds one unified byte-wide array that serves both instruction fetch and data access. A side-band preload port lets benches and boot logic fill the array before the CPU runs.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_array.sv | 32 +++
 rtl/mem_responder.sv | 170 +++++++++++++++++
 tb/tb_mem_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and default sizing for the memory responder.
//   state_t        : responder FSM states (idle, wait states, response).
//   op_t           : latched request type (read / write).
//   MEM_*          : default parameter values for mem_responder.
//   addr_in_range  : bounds check of an address against an implemented depth.
package mem_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 8;
  localparam int MEM_DEPTH  = 256;
  localparam int MEM_WAIT   = 2;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // True when the (zero-extended) address selects an implemented word.
  function automatic logic addr_in_range(input logic [31:0] a, input logic [31:0] depth);
    return (a < depth) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH x DATA_W unified storage, not reset.
//   clk    : write clock
//   we     : synchronous write enable (preload or committed write, muxed upstream)
//   waddr  : write index
//   wdata  : write data
//   raddr  : combinational read index
//   rdata  : combinational read data
module mem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Single synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-state memory responder for the multicycle CPU's shared
// instruction/data port. Captures a read/write strobe, inserts WAIT wait
// states, then completes with a one-cycle ready pulse (err flags illegal
// accesses). A preload port fills the array while the responder is idle.
//   clk, rst               : clock, asynchronous active-low reset
//   addr, wdata            : request address / write data
//   memread, memwrite      : level request strobes
//   rdata, ready, err, busy: registered response outputs
//   load_en/addr/data      : preload write port (idle only)
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int DEPTH  = MEM_DEPTH,
  parameter int WAIT   = MEM_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              memread,
  input  logic              memwrite,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              busy,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  op_t                r_op;
  logic               r_both;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_ready;
  logic               r_err;
  logic               r_busy;

  logic               w_req;
  logic               w_enter_resp;
  logic [ADDR_W-1:0]  w_cur_addr;
  logic               w_cur_rd;
  logic               w_cur_illegal;
  logic               w_we;
  logic [IDX_W-1:0]   w_waddr;
  logic [DATA_W-1:0]  w_wdata;
  logic [DATA_W-1:0]  w_rd_data;

  assign w_req = memread | memwrite;

  // With WAIT=0 the response is entered on the acceptance edge itself, so the
  // response values come from the live request; otherwise from the latches.
  assign w_enter_resp = ((r_state == ST_IDLE) && !load_en && w_req && (WAIT == 0)) ||
                        ((r_state == ST_WAIT) && (r_cnt <= 4'd1));
  assign w_cur_addr    = (r_state == ST_IDLE) ? addr : r_addr;
  assign w_cur_rd      = (r_state == ST_IDLE) ? !memwrite : (r_op == OP_RD);
  assign w_cur_illegal = ((r_state == ST_IDLE) ? (memread & memwrite) : r_both) |
                         !addr_in_range(32'(w_cur_addr), 32'(DEPTH));

  // Write port mux: committed write in RESP (r_err already holds legality), preload in IDLE.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = {IDX_W{1'b0}};
    w_wdata = {DATA_W{1'b0}};
    if (r_state == ST_RESP) begin
      if ((r_op == OP_WR) && !r_err) begin
        w_we    = 1'b1;
        w_waddr = r_addr[IDX_W-1:0];
        w_wdata = r_wdata;
      end else begin
        w_we    = 1'b0;
      end
    end else if ((r_state == ST_IDLE) && load_en &&
                 addr_in_range(32'(load_addr), 32'(DEPTH))) begin
      w_we    = 1'b1;
      w_waddr = load_addr[IDX_W-1:0];
      w_wdata = load_data;
    end else begin
      w_we    = 1'b0;
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (w_wdata),
    .raddr (w_cur_addr[IDX_W-1:0]),
    .rdata (w_rd_data)
  );

  // Responder FSM, request latches, wait counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= {ADDR_W{1'b0}};
      r_wdata <= {DATA_W{1'b0}};
      r_op    <= OP_RD;
      r_both  <= 1'b0;
      r_rdata <= {DATA_W{1'b0}};
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load_en) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_req) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_op    <= memwrite ? OP_WR : OP_RD;
            r_both  <= memread & memwrite;
            r_cnt   <= 4'(WAIT);
            r_busy  <= 1'b1;
            r_state <= (WAIT == 0) ? ST_RESP : ST_WAIT;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_WAIT: begin
          r_cnt   <= r_cnt - 4'd1;
          r_busy  <= 1'b1;
          r_state <= (r_cnt <= 4'd1) ? ST_RESP : ST_WAIT;
        end
        ST_RESP: begin
          r_cnt   <= 4'd0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_cnt   <= 4'd0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
      // Response outputs are loaded on the edge that enters RESP; rdata only
      // changes on reads and returns zero for an illegal read.
      if (w_enter_resp) begin
        r_ready <= 1'b1;
        r_err   <= w_cur_illegal;
        if (w_cur_rd) begin
          r_rdata <= w_cur_illegal ? {DATA_W{1'b0}} : w_rd_data;
        end
      end
    end
  end

  assign rdata = r_rdata;
  assign ready = r_ready;
  assign err   = r_err;
  assign busy  = r_busy;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WAIT=2, DEPTH=256. Instance B: WAIT=0, DEPTH=128.
  logic       rst_a = 1'b1, rst_b = 1'b1;
  logic [7:0] a_addr = 8'h00, a_wdata = 8'h00, a_load_addr = 8'h00, a_load_data = 8'h00;
  logic       a_memread = 1'b0, a_memwrite = 1'b0, a_load_en = 1'b0;
  logic [7:0] a_rdata;
  logic       a_ready, a_err, a_busy;
  logic [7:0] b_addr = 8'h00, b_wdata = 8'h00, b_load_addr = 8'h00, b_load_data = 8'h00;
  logic       b_memread = 1'b0, b_memwrite = 1'b0, b_load_en = 1'b0;
  logic [7:0] b_rdata;
  logic       b_ready, b_err, b_busy;

  mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT(2)) u_a (
    .clk(clk), .rst(rst_a), .addr(a_addr), .wdata(a_wdata),
    .memread(a_memread), .memwrite(a_memwrite), .rdata(a_rdata),
    .ready(a_ready), .err(a_err), .busy(a_busy), .load_en(a_load_en),
    .load_addr(a_load_addr), .load_data(a_load_data)
  );

  mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .WAIT(0)) u_b (
    .clk(clk), .rst(rst_b), .addr(b_addr), .wdata(b_wdata),
    .memread(b_memread), .memwrite(b_memwrite), .rdata(b_rdata),
    .ready(b_ready), .err(b_err), .busy(b_busy), .load_en(b_load_en),
    .load_addr(b_load_addr), .load_data(b_load_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input bit b, input logic [7:0] ad, input logic [7:0] d);
    if (b) begin
      b_load_en = 1'b1; b_load_addr = ad; b_load_data = d;
    end else begin
      a_load_en = 1'b1; a_load_addr = ad; a_load_data = d;
    end
    step();
    a_load_en = 1'b0;
    b_load_en = 1'b0;
  endtask

  // Raise strobes, wait (bounded) for ready, drop strobes, confirm ready falls.
  task automatic access(input bit b, input logic rd, input logic wr,
                        input logic [7:0] ad, input logic [7:0] wd,
                        output int lat, output logic [7:0] rv, output logic ev);
    lat = -1; rv = 8'h00; ev = 1'b0;
    if (b) begin
      b_addr = ad; b_wdata = wd; b_memread = rd; b_memwrite = wr;
    end else begin
      a_addr = ad; a_wdata = wd; a_memread = rd; a_memwrite = wr;
    end
    for (int i = 0; i < 20; i++) begin
      step();
      if ((b ? b_ready : a_ready) === 1'b1) begin
        lat = i + 1;
        rv  = b ? b_rdata : a_rdata;
        ev  = b ? b_err : a_err;
        break;
      end
    end
    a_memread = 1'b0; a_memwrite = 1'b0;
    b_memread = 1'b0; b_memwrite = 1'b0;
    step();
    chk("ready_low_after", {31'd0, (b ? b_ready : a_ready)}, 32'd0);
  endtask

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       chk_rd;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int         lat;
    logic [7:0] rv;
    logic       ev;
    int         t1, t2;

    vecs[0] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h22, 8'h3C, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h22, 8'h00, 1'b1, 8'h3C, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'h05, 8'hEE, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 8'h11, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'h22, 8'h5A, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 8'h22, 8'h00, 1'b1, 8'h5A, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 8'hFF, 8'h81, 1'b0, 8'h00, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h81, 1'b0};

    // Asynchronous reset before the first clock edge.
    #2;
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    chk("rst_rdata", {24'd0, a_rdata}, 32'd0);
    chk("rst_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_err",   {31'd0, a_err},   32'd0);
    chk("rst_busy",  {31'd0, a_busy},  32'd0);
    step(); step();
    rst_a = 1'b1; rst_b = 1'b1;
    step();

    preload(1'b0, 8'h10, 8'hA5);
    preload(1'b0, 8'h05, 8'h11);
    preload(1'b0, 8'h30, 8'h44);

    // Table-driven accesses on instance A (WAIT=2 -> ready 3 cycles after acceptance).
    for (int v = 0; v < 9; v++) begin
      access(1'b0, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, lat, rv, ev);
      chk($sformatf("vec%0d_latency", v), lat, 32'd3);
      chk($sformatf("vec%0d_err", v), {31'd0, ev}, {31'd0, vecs[v].exp_err});
      if (vecs[v].chk_rd) begin
        chk($sformatf("vec%0d_rdata", v), {24'd0, rv}, {24'd0, vecs[v].exp_rdata});
      end
    end

    // Back-to-back reads with the strobe held: completions WAIT+2 = 4 cycles apart.
    t1 = -1; t2 = -1;
    a_addr = 8'h10; a_memread = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (a_ready === 1'b1) begin
        chk("b2b_rdata", {24'd0, a_rdata}, 32'h0000_00A5);
        if (t1 < 0) begin
          t1 = i;
        end else begin
          t2 = i;
          break;
        end
      end
    end
    a_memread = 1'b0;
    step();
    chk("b2b_period", t2 - t1, 32'd4);

    // Preload and strobe together: preload wins, access accepted one cycle later.
    a_load_en = 1'b1; a_load_addr = 8'h40; a_load_data = 8'h9C;
    a_memread = 1'b1; a_addr = 8'h40;
    step();
    chk("load_blocks_busy", {31'd0, a_busy}, 32'd0);
    a_load_en = 1'b0;
    access(1'b0, 1'b1, 1'b0, 8'h40, 8'h00, lat, rv, ev);
    chk("load_then_read_lat", lat, 32'd3);
    chk("load_then_read_rdata", {24'd0, rv}, 32'h0000_009C);

    // Reset during the wait states of a write: write abandoned, outputs cleared at once.
    a_addr = 8'h30; a_wdata = 8'h99; a_memwrite = 1'b1;
    step();
    step();
    chk("mid_busy", {31'd0, a_busy}, 32'd1);
    rst_a = 1'b0;
    #1;
    chk("mid_rst_busy",  {31'd0, a_busy},  32'd0);
    chk("mid_rst_ready", {31'd0, a_ready}, 32'd0);
    chk("mid_rst_err",   {31'd0, a_err},   32'd0);
    chk("mid_rst_rdata", {24'd0, a_rdata}, 32'd0);
    a_memwrite = 1'b0;
    step();
    rst_a = 1'b1;
    step();
    access(1'b0, 1'b1, 1'b0, 8'h30, 8'h00, lat, rv, ev);
    chk("after_rst_rdata", {24'd0, rv}, 32'h0000_0044);

    // Instance B: WAIT=0, DEPTH=128.
    preload(1'b1, 8'h00, 8'h7E);
    preload(1'b1, 8'h10, 8'h33);
    preload(1'b1, 8'h90, 8'hEE);
    access(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, lat, rv, ev);
    chk("w0_latency", lat, 32'd1);
    chk("w0_rdata", {24'd0, rv}, 32'h0000_007E);
    chk("w0_err", {31'd0, ev}, 32'd0);
    access(1'b1, 1'b1, 1'b0, 8'h80, 8'h00, lat, rv, ev);
    chk("oob_latency", lat, 32'd1);
    chk("oob_err", {31'd0, ev}, 32'd1);
    chk("oob_rdata", {24'd0, rv}, 32'd0);
    access(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, lat, rv, ev);
    chk("oob_preload_dropped", {24'd0, rv}, 32'h0000_0033);
    access(1'b1, 1'b0, 1'b1, 8'h85, 8'h55, lat, rv, ev);
    chk("oob_write_err", {31'd0, ev}, 32'd1);
    access(1'b1, 1'b1, 1'b0, 8'h05, 8'h00, lat, rv, ev);
    chk("oob_write_dropped_err", {31'd0, ev}, 32'd0);
    access(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, lat, rv, ev);
    chk("oob_write_no_alias", {24'd0, rv}, 32'h0000_0033);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
